// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock mode/time-setting sequencer.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [MIN_W-1:0]  MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  // Hours step 0..23 and wrap back to 0.
  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    return (h == MAX_HOUR) ? '0 : h + HOUR_W'(1);
  endfunction

  // Minutes and seconds share the same 0..59 wrap.
  function automatic logic [MIN_W-1:0] next_sixty(input logic [MIN_W-1:0] v);
    return (v == MAX_MIN) ? '0 : v + MIN_W'(1);
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Two-stage rising-edge detector for an already-synchronised push-button.
// Emits a one-cycle pulse per press; 'level' exposes the first stage.
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse,
  output logic level
);

  logic s0;
  logic s1;

  // Shift the button through two stages so a rise shows up as s0 & ~s1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn;
      s1 <= s0;
    end
  end

  assign pulse = s0 & ~s1;
  assign level = s0;

endmodule

// File: rtl/clock_set_controller.sv
// Mode/time-setting sequencer: RUN / SET_HR / SET_MIN state machine that owns
// the HH:MM:SS counters. Optional auto-repeat on a held increment button is
// enabled by defining the macro AUTO_REPEAT_EN.
module clock_set_controller
  import clock_pkg::*;
`ifdef AUTO_REPEAT_EN
  #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
  )
`endif
  (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              tick_1hz,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [MIN_W-1:0]  seconds,
  output logic [1:0]        mode,
  output logic [1:0]        blink_sel
);

  mode_t             state_q, state_d;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  minutes_q, minutes_d;
  logic [MIN_W-1:0]  seconds_q, seconds_d;

  logic mode_pulse;
  logic inc_pulse;
  logic inc_level;
  logic inc_evt;
  logic mode_level_unused;

  btn_pulse u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_pulse),
    .level (mode_level_unused)
  );

  btn_pulse u_inc_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .pulse (inc_pulse),
    .level (inc_level)
  );

`ifdef AUTO_REPEAT_EN
  // The hold counter is compared only against FIRE_AT. After each repeat it is
  // reloaded so that exactly REPEAT_RATE cycles later it reaches FIRE_AT again;
  // the reload value is taken modulo 2^32, so a rate larger than the delay works.
  localparam logic [31:0] FIRE_AT = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RELOAD  = 32'(REPEAT_DELAY - REPEAT_RATE);

  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        repeat_hit;

  // Count cycles the increment button has been held in a set mode and fire repeats.
  always_comb begin
    repeat_hit = 1'b0;
    hold_cnt_d = hold_cnt_q;
    if (state_q == MODE_RUN || !inc_level || mode_pulse) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q == FIRE_AT) begin
      repeat_hit = 1'b1;
      hold_cnt_d = RELOAD;
    end else begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end

  assign inc_evt = inc_pulse | repeat_hit;
`else
  logic inc_level_unused;
  assign inc_level_unused = inc_level;
  assign inc_evt          = inc_pulse;
`endif

  // Next-state and next-count logic; a mode press always beats an increment.
  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    case (state_q)
      MODE_RUN: begin
        if (tick_1hz) begin
          seconds_d = next_sixty(seconds_q);
          if (seconds_q == MAX_SEC) begin
            minutes_d = next_sixty(minutes_q);
            if (minutes_q == MAX_MIN) begin
              hours_d = next_hour(hours_q);
            end
          end
        end
        if (mode_pulse) begin
          state_d = MODE_SET_HR;
        end
      end
      MODE_SET_HR: begin
        if (mode_pulse) begin
          state_d = MODE_SET_MIN;
        end else if (inc_evt) begin
          hours_d = next_hour(hours_q);
        end
      end
      MODE_SET_MIN: begin
        if (mode_pulse) begin
          state_d   = MODE_RUN;
          seconds_d = '0;
        end else if (inc_evt) begin
          minutes_d = next_sixty(minutes_q);
        end
      end
      default: begin
        state_d = MODE_RUN;
      end
    endcase
  end

  // State and time registers; reset discards any partial setting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MODE_RUN;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign mode      = state_q;
  assign blink_sel = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: vector table plus hand-written
// sequences for pulse latency, coincident events, reset and button hold.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic       tick_1hz;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic [1:0] blink_sel;

  int n_applied    = 0;
  int n_miscompare = 0;

  typedef struct packed {
    logic       bm;
    logic       bi;
    logic       t0;
    logic       t1;
    logic [7:0] reps;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

`ifdef AUTO_REPEAT_EN
  clock_set_controller #(.REPEAT_DELAY(10), .REPEAT_RATE(4)) dut (
`else
  clock_set_controller dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .tick_1hz  (tick_1hz),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .mode      (mode),
    .blink_sel (blink_sel)
  );

  function automatic vec_t mk(input logic bm, input logic bi, input logic t0, input logic t1,
                              input int reps, input int h, input int m, input int s, input int md);
    vec_t v;
    v.bm   = bm;
    v.bi   = bi;
    v.t0   = t0;
    v.t1   = t1;
    v.reps = 8'(reps);
    v.h    = 5'(h);
    v.m    = 6'(m);
    v.s    = 6'(s);
    v.md   = 2'(md);
    return v;
  endfunction

  task automatic compare(input string name, input int got, input int want);
    n_applied++;
    if (got != want) begin
      n_miscompare++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input int h, input int m, input int s, input int md);
    compare({tag, ".hours"},     int'(hours),     h);
    compare({tag, ".minutes"},   int'(minutes),   m);
    compare({tag, ".seconds"},   int'(seconds),   s);
    compare({tag, ".mode"},      int'(mode),      md);
    compare({tag, ".blink_sel"}, int'(blink_sel), md);
  endtask

  // Buttons and t0 are sampled at edge k, the button pulse and t1 act at edge k+1.
  task automatic applyStimulus(input logic bm, input logic bi, input logic t0, input logic t1);
    @(negedge clk);
    btn_mode = bm;
    btn_inc  = bi;
    tick_1hz = t0;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = t1;
    @(negedge clk);
    tick_1hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;

    //           bm bi t0 t1 reps  h   m   s  md
    vecs[0]  = mk(0, 0, 1, 0, 61,  0,  1,  1, 0);
    vecs[1]  = mk(1, 0, 0, 0,  1,  0,  1,  1, 1);
    vecs[2]  = mk(0, 0, 1, 0,  3,  0,  1,  1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 25,  1,  1,  1, 1);
    vecs[4]  = mk(1, 0, 0, 0,  1,  1,  1,  1, 2);
    vecs[5]  = mk(0, 1, 0, 0, 61,  1,  2,  1, 2);
    vecs[6]  = mk(1, 0, 0, 0,  1,  1,  2,  0, 0);
    vecs[7]  = mk(0, 1, 0, 0,  3,  1,  2,  0, 0);
    vecs[8]  = mk(0, 0, 1, 0,  5,  1,  2,  5, 0);
    vecs[9]  = mk(1, 0, 0, 0,  1,  1,  2,  5, 1);
    vecs[10] = mk(0, 1, 0, 0, 22, 23,  2,  5, 1);
    vecs[11] = mk(1, 0, 0, 0,  1, 23,  2,  5, 2);
    vecs[12] = mk(0, 1, 0, 0, 57, 23, 59,  5, 2);
    vecs[13] = mk(1, 0, 0, 0,  1, 23, 59,  0, 0);
    vecs[14] = mk(0, 0, 1, 0, 58, 23, 59, 58, 0);
    vecs[15] = mk(0, 0, 1, 0,  1, 23, 59, 59, 0);
    vecs[16] = mk(0, 0, 1, 0,  1,  0,  0,  0, 0);
    vecs[17] = mk(0, 0, 1, 0,  1,  0,  0,  1, 0);
    vecs[18] = mk(1, 0, 0, 1,  1,  0,  0,  2, 1);
    vecs[19] = mk(1, 1, 0, 0,  1,  0,  0,  2, 2);
    vecs[20] = mk(0, 1, 0, 0,  1,  0,  1,  2, 2);
    vecs[21] = mk(1, 0, 0, 1,  1,  0,  1,  0, 0);
    vecs[22] = mk(0, 0, 1, 1,  1,  0,  1,  2, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      for (int r = 0; r < int'(vecs[i].reps); r++) begin
        applyStimulus(vecs[i].bm, vecs[i].bi, vecs[i].t0, vecs[i].t1);
      end
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].h), int'(vecs[i].m),
                  int'(vecs[i].s), int'(vecs[i].md));
    end

    // Held mode button: one transition, two edges after the rise.
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    compare("latency.after_edge1", int'(mode), 0);
    @(negedge clk);
    compare("latency.after_edge2", int'(mode), 1);
    repeat (98) @(negedge clk);
    compare("latency.held100", int'(mode), 1);
    btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("latency.released", 0, 1, 2, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("latency.back_run", 0, 1, 0, 0);

    // Reset mid-setting at 12:34 in SET_MIN, with btn_mode held through reset.
    pulseReset();
    checkOutput("rst1", 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 12; r++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 34; r++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("preset_1234", 12, 34, 0, 2);
    @(negedge clk);
    rst_n    = 1'b0;
    btn_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid_set", 0, 0, 0, 0);
    @(negedge clk);
    compare("rst_btn.after_edge1", int'(mode), 0);
    @(negedge clk);
    compare("rst_btn.after_edge2", int'(mode), 1);
    btn_mode = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("to_set_min", 0, 0, 0, 2);

    // Hold the increment button for 30 edges in SET_MIN from minute 0.
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (30) @(negedge clk);
    btn_inc = 1'b0;
    repeat (3) @(negedge clk);
`ifdef AUTO_REPEAT_EN
    checkOutput("hold_inc_repeat", 0, 7, 0, 2);
`else
    checkOutput("hold_inc_single", 0, 1, 0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule
